matrix_io_sequencer: RTL and testbench
======================================

# matrix_io_sequencer

Host-side command sequencer that sits directly upstream of the coprocessor control unit and drives its 32-bit instruction word. It accepts whole-matrix commands from the HPS bridge (store matrix A, store matrix B, execute an arithmetic opcode, read back the result) and expands each command into the control unit's per-word instruction stream. Each issued instruction is held stable and paced by a fixed control-unit latency. Read-back words are reassembled into a 200-bit result matrix, and the overflow flag is latched after each execute.

## Interface
- CU_LATENCY, 5: cycles the instruction is held after the start cycle; must cover the control unit's FETCH/DECODE/EXECUTE/WRITEBACK walk; legal range 4..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_kind  in  2  00 store A (opcode 0111), 01 store B (opcode 1000), 10 execute, 11 load result (opcode 1001).
- cmd_opcode  in  4  arithmetic opcode for execute; legal values 0000..0110.
- cmd_msize  in  2  matrix size code 0..3 = 2x2..5x5; forwarded in every instruction.
- cmd_matrix  in  200  row-major 5x5 int8 matrix; element (0,0) is in [199:192].
- instruction  out  32  to control unit: [0] start, [4:1] position, [6:5] msize, [10:7] opcode, [26:11] data, [31:27] zero.
- cu_data  in  32  control unit package_data_out.
- cu_overflow  in  1  control unit overflow.
- result_matrix  out  200  reassembled result; updated only by load.
- overflow_flag  out  1  cu_overflow sampled at the end of the last execute.
- done  out  1  one-cycle pulse when a command completes.
- cmd_error  out  1  one-cycle pulse, coincident with done, for an illegal execute opcode.

## Operation
- Reset values: instruction, result_matrix, overflow_flag, done and cmd_error are all 0. cmd_ready is 1 and the state is IDLE.
- States:
  - IDLE: accept the command on cmd_valid && cmd_ready. Latch kind, opcode, msize and matrix. Set idx=0, then go to ISSUE.
  - ISSUE (1 cycle): drive the instruction for word idx with bit0=1. Clear cnt, then go to WAIT.
  - WAIT: same instruction, bit0=0. cnt increments each cycle. When cnt==CU_LATENCY-1, go to ISSUE if more words remain (idx++), else go to DONE.
  - DONE (1 cycle): pulse done, then return to IDLE.
- Store A/B: 13 words, positions 0..12.
  - Position k<12 carries data = matrix[199-16k -: 16].
  - Position 12 carries [26:19]=matrix[7:0] and [18:11]=0.
- Load: 7 words, positions 0..6, data field 0.
  - On the final WAIT cycle of word k<6, capture result_matrix[199-32k -: 32] = cu_data.
  - For k=6, capture result_matrix[7:0] = cu_data[31:24].
  - Other bits are untouched.
- Execute: 1 word, position 0, data 0, opcode = cmd_opcode. On the final WAIT cycle, overflow_flag ← cu_overflow.
- Execute with cmd_opcode ≥ 0111: issue nothing. Go IDLE→DONE, pulse done and cmd_error, and leave overflow_flag unchanged.
- overflow_flag is not changed by store or load.
- The instruction keeps its last value (bit0=0) in IDLE; bit0 is 1 only in ISSUE.

## Timing
- Per word: 1 + CU_LATENCY cycles.
- From the accept edge to done high:
  - store 13·(1+CU_LATENCY)+1 = 79 cycles;
  - load 7·(1+CU_LATENCY)+1 = 43 cycles;
  - execute 7 cycles;
  - illegal execute 1 cycle (all at default CU_LATENCY).
- cmd_ready is 0 from the cycle after acceptance until IDLE is re-entered. Back-to-back commands: the next accept is possible the cycle after done.
- cmd_valid while busy is ignored; the command inputs are not sampled.
- rst mid-command: immediate return to IDLE. instruction is 0 and no done pulse is produced. result_matrix and overflow_flag clear; partial loads are discarded.
- Start bit high for exactly one cycle per word, so the control unit never re-triggers from its WRITEBACK→IDLE return.

## Structure
- Shared package: the control-unit opcode constants (0000..1001), the instruction field positions, the cmd_kind encodings, and the state enum.
- One sub-module is natural: matrix_word_slicer. It is combinational and maps (kind, idx, matrix) to the 16-bit data field and the result-slice write enable and offset. The FSM, counters and capture stay in the top module.

## Test plan
- Store A, matrix bytes 0x01..0x19 row-major: 13 ISSUE cycles 6 apart. Position 0 data 0x0102, position 11 data 0x1718, position 12 instruction[26:11]=0x1900, opcode 0111. done 79 cycles after accept.
- Load with a cu_data model returning 0xA0000000+k on word k: result_matrix[199:168]=0xA0000000, [39:8]=0xA0000005, [7:0]=0xA0. done at cycle 43.
- Execute opcode 0100, msize 11, cu_overflow=1 on the final WAIT cycle: instruction[10:5]=0b010011, overflow_flag=1, done at cycle 7.
- Execute opcode 1010: done and cmd_error pulse one cycle after accept, no instruction issued (bit0 never 1), overflow_flag unchanged.
- cmd_valid held high with a second command during a store: the second command is ignored until done, then accepted the next cycle.
- rst asserted at word 5 of a store: instruction=0 and cmd_ready=1 immediately, no done pulse. A following store runs a full 79 cycles.

Source files
------------

// File: rtl/matrix_io_sequencer_pkg.sv
// Shared types and constants for the host-side matrix command sequencer
// and the control-unit instruction word it drives.
package matrix_io_sequencer_pkg;

  typedef enum logic [1:0] {
    KIND_STORE_A = 2'b00,
    KIND_STORE_B = 2'b01,
    KIND_EXEC    = 2'b10,
    KIND_LOAD    = 2'b11
  } cmd_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Control-unit opcodes: 0000..0110 are arithmetic, the rest move data.
  localparam logic [3:0] OP_ARITH_LAST = 4'b0110;
  localparam logic [3:0] OP_STORE_A    = 4'b0111;
  localparam logic [3:0] OP_STORE_B    = 4'b1000;
  localparam logic [3:0] OP_LOAD       = 4'b1001;

  localparam int INSTR_START     = 0;
  localparam int INSTR_POS_LSB   = 1;
  localparam int INSTR_MSIZE_LSB = 5;
  localparam int INSTR_OP_LSB    = 7;
  localparam int INSTR_DATA_LSB  = 11;

  localparam int STORE_WORDS = 13;
  localparam int LOAD_WORDS  = 7;
  localparam int EXEC_WORDS  = 1;

  function automatic logic [3:0] last_word(input cmd_kind_t kind);
    logic [3:0] w;
    w = 4'(EXEC_WORDS - 1);
    case (kind)
      KIND_STORE_A, KIND_STORE_B: w = 4'(STORE_WORDS - 1);
      KIND_LOAD:                  w = 4'(LOAD_WORDS - 1);
      default:                    w = 4'(EXEC_WORDS - 1);
    endcase
    return w;
  endfunction

  function automatic logic [31:0] pack_instr(input logic [3:0] pos, input logic [1:0] msize,
                                             input logic [3:0] op, input logic [15:0] data,
                                             input logic start);
    logic [31:0] w;
    w = '0;
    w[INSTR_START]          = start;
    w[INSTR_POS_LSB +: 4]   = pos;
    w[INSTR_MSIZE_LSB +: 2] = msize;
    w[INSTR_OP_LSB +: 4]    = op;
    w[INSTR_DATA_LSB +: 16] = data;
    return w;
  endfunction

endpackage

// File: rtl/matrix_io_sequencer_if.sv
// Host command channel plus control-unit instruction/result signals.
interface matrix_io_sequencer_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_kind;
  logic [3:0]   cmd_opcode;
  logic [1:0]   cmd_msize;
  logic [199:0] cmd_matrix;
  logic [31:0]  instruction;
  logic [31:0]  cu_data;
  logic         cu_overflow;
  logic [199:0] result_matrix;
  logic         overflow_flag;
  logic         done;
  logic         cmd_error;

  modport master (
    output cmd_valid, cmd_kind, cmd_opcode, cmd_msize, cmd_matrix, cu_data, cu_overflow,
    input  cmd_ready, instruction, result_matrix, overflow_flag, done, cmd_error
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_opcode, cmd_msize, cmd_matrix, cu_data, cu_overflow,
    output cmd_ready, instruction, result_matrix, overflow_flag, done, cmd_error
  );
endinterface

// File: rtl/matrix_word_slicer.sv
// Maps (kind, word index, matrix) to the instruction data field and to the
// result-matrix slice that a load word writes.
module matrix_word_slicer
  import matrix_io_sequencer_pkg::*;
(
  input  cmd_kind_t    kind,
  input  logic [3:0]   idx,
  input  logic [199:0] matrix,
  output logic [15:0]  data,
  output logic         res_we,
  output logic         res_byte,
  output logic [7:0]   res_off
);

  logic [7:0] store_lsb;

  assign store_lsb = 8'd184 - {idx, 4'b0000};

  always_comb begin
    data     = '0;
    res_we   = 1'b0;
    res_byte = 1'b0;
    res_off  = '0;
    case (kind)
      KIND_STORE_A, KIND_STORE_B: begin
        // The 25th element rides alone in the upper byte of the last word.
        if (idx < 4'd12) data = matrix[store_lsb +: 16];
        else             data = {matrix[7:0], 8'h00};
      end
      KIND_LOAD: begin
        res_we = 1'b1;
        if (idx < 4'd6) res_off = 8'd168 - {idx[2:0], 5'b00000};
        else            res_byte = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/matrix_io_sequencer.sv
// Expands whole-matrix host commands into the control unit's per-word
// instruction stream, pacing each word by CU_LATENCY cycles.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a host command
// ISSUE | instruction driven with start bit set (one cycle)
// WAIT  | start low, counting out the control-unit latency
// DONE  | command finished; done pulses on the following cycle
module matrix_io_sequencer
  import matrix_io_sequencer_pkg::*;
#(
  parameter int CU_LATENCY = 5
) (
  input logic              clk,
  input logic              rst,
  matrix_io_sequencer_if.slave bus
);

  localparam logic [3:0] CNT_LAST = 4'(CU_LATENCY - 1);

  state_t       state, state_nxt;
  cmd_kind_t    kind_q;
  logic [3:0]   op_q;
  logic [1:0]   msize_q;
  logic [199:0] matrix_q;
  logic         err_q;
  logic [3:0]   idx, cnt;
  logic [31:0]  instr_last;
  logic [199:0] result_q;
  logic         ovf_q, done_q, err_pulse_q;

  logic         accept, illegal, last_wait;
  logic [3:0]   op_cur;
  logic [31:0]  instr_cur;
  logic [15:0]  data;
  logic         res_we, res_byte;
  logic [7:0]   res_off;

  matrix_word_slicer u_slicer (
    .kind     (kind_q),
    .idx      (idx),
    .matrix   (matrix_q),
    .data     (data),
    .res_we   (res_we),
    .res_byte (res_byte),
    .res_off  (res_off)
  );

  assign illegal   = (cmd_kind_t'(bus.cmd_kind) == KIND_EXEC) && (bus.cmd_opcode > OP_ARITH_LAST);
  assign last_wait = (state == ST_WAIT) && (cnt == CNT_LAST);

  always_comb begin
    case (kind_q)
      KIND_STORE_A: op_cur = OP_STORE_A;
      KIND_STORE_B: op_cur = OP_STORE_B;
      KIND_LOAD:    op_cur = OP_LOAD;
      default:      op_cur = op_q;
    endcase
  end

  assign instr_cur = pack_instr(idx, msize_q, op_cur, data, state == ST_ISSUE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = illegal ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (last_wait) state_nxt = (idx == last_word(kind_q)) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q      <= KIND_STORE_A;
      op_q        <= '0;
      msize_q     <= '0;
      matrix_q    <= '0;
      err_q       <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
      instr_last  <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      done_q      <= (state == ST_DONE);
      err_pulse_q <= (state == ST_DONE) && err_q;
      if (accept) begin
        kind_q   <= cmd_kind_t'(bus.cmd_kind);
        op_q     <= bus.cmd_opcode;
        msize_q  <= bus.cmd_msize;
        matrix_q <= bus.cmd_matrix;
        err_q    <= illegal;
        idx      <= '0;
      end
      if (state == ST_ISSUE) cnt <= '0;
      if (state == ST_WAIT) begin
        cnt        <= cnt + 4'd1;
        instr_last <= {instr_cur[31:1], 1'b0};
      end
      if (last_wait) begin
        if (idx != last_word(kind_q)) idx <= idx + 4'd1;
        if (kind_q == KIND_EXEC) ovf_q <= bus.cu_overflow;
        if (res_we) begin
          if (res_byte) result_q[7:0] <= bus.cu_data[31:24];
          else          result_q[res_off +: 32] <= bus.cu_data;
        end
      end
    end
  end

  // Outside a command the control unit sees the last word with start low.
  assign bus.instruction   = (state == ST_ISSUE || state == ST_WAIT) ? instr_cur : instr_last;
  assign bus.cmd_ready     = (state == ST_IDLE);
  assign bus.result_matrix = result_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.done          = done_q;
  assign bus.cmd_error     = err_pulse_q;

endmodule

// File: tb/tb_matrix_io_sequencer.sv
// Directed bench for matrix_io_sequencer at the default CU_LATENCY of 5.
module tb_matrix_io_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int          n;
  int          n_done;
  int          n_starts;
  logic [31:0] start_instr [16];
  int          start_cyc   [16];
  logic [199:0] mat_a;

  matrix_io_sequencer_if bus();

  matrix_io_sequencer #(.CU_LATENCY(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_cmd(input logic [1:0] kind, input logic [3:0] op,
                            input logic [1:0] msize, input logic [199:0] m);
    bus.cmd_kind   = kind;
    bus.cmd_opcode = op;
    bus.cmd_msize  = msize;
    bus.cmd_matrix = m;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  // Runs from the first cycle after acceptance (n=0) until done, acting as
  // the control unit: word k returns 0xA0000000+k, overflow only on ovf_cycle.
  task automatic run_cmd(input int ovf_cycle);
    n = 0; n_done = -1; n_starts = 0;
    for (int i = 0; i < 16; i++) begin start_instr[i] = '1; start_cyc[i] = -1; end
    while (n < 300) begin
      if (bus.instruction[0]) begin
        if (n_starts < 16) begin
          start_instr[n_starts] = bus.instruction;
          start_cyc[n_starts]   = n;
        end
        n_starts++;
      end
      if (bus.done) begin n_done = n; break; end
      bus.cu_data     = 32'hA000_0000 + 32'(n / 6);
      bus.cu_overflow = (n == ovf_cycle);
      tick();
      n++;
    end
    bus.cu_overflow = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_kind = '0; bus.cmd_opcode = '0; bus.cmd_msize = '0;
    bus.cmd_matrix = '0; bus.cu_data = '0; bus.cu_overflow = 1'b0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", bus.instruction); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
    checks++; if (bus.done !== 1'b0 || bus.cmd_error !== 1'b0) begin errors++; $display("FAIL reset_pulses done=%b err=%b exp=0", bus.done, bus.cmd_error); end
    checks++; if (bus.result_matrix !== 200'h0 || bus.overflow_flag !== 1'b0) begin errors++; $display("FAIL reset_result ovf=%b result=%h exp=0", bus.overflow_flag, bus.result_matrix); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_a();
    for (int i = 0; i < 25; i++) mat_a[199 - 8*i -: 8] = 8'(i + 1);
    accept_cmd(2'b00, 4'b0000, 2'b10, mat_a);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL store_busy_ready got=%b exp=0", bus.cmd_ready); end
    run_cmd(-1);
    checks++; if (n_done !== 79) begin errors++; $display("FAIL store_done_cycle got=%0d exp=79", n_done); end
    checks++; if (n_starts !== 13) begin errors++; $display("FAIL store_start_count got=%0d exp=13", n_starts); end
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (start_cyc[k] !== 6*k || start_instr[k][4:1] !== 4'(k) || start_instr[k][10:7] !== 4'b0111
          || start_instr[k][6:5] !== 2'b10 || start_instr[k][31:27] !== 5'b0) begin
        errors++; $display("FAIL store_word%0d cyc=%0d instr=%h exp cyc=%0d pos=%0d op=7 msize=2", k, start_cyc[k], start_instr[k], 6*k, k);
      end
      if (k < 12) begin
        checks++;
        if (start_instr[k][26:11] !== {8'(2*k + 1), 8'(2*k + 2)}) begin
          errors++; $display("FAIL store_data%0d got=%h exp=%h", k, start_instr[k][26:11], {8'(2*k + 1), 8'(2*k + 2)});
        end
      end
    end
    checks++; if (start_instr[0][26:11] !== 16'h0102) begin errors++; $display("FAIL store_pos0 got=%h exp=0102", start_instr[0][26:11]); end
    checks++; if (start_instr[11][26:11] !== 16'h1718) begin errors++; $display("FAIL store_pos11 got=%h exp=1718", start_instr[11][26:11]); end
    checks++; if (start_instr[12][26:11] !== 16'h1900) begin errors++; $display("FAIL store_pos12 got=%h exp=1900", start_instr[12][26:11]); end
    checks++; if (bus.cmd_error !== 1'b0) begin errors++; $display("FAIL store_no_error got=%b exp=0", bus.cmd_error); end
    tick();
  endtask

  task automatic test_load();
    accept_cmd(2'b11, 4'b0000, 2'b00, '0);
    run_cmd(-1);
    checks++; if (n_done !== 43) begin errors++; $display("FAIL load_done_cycle got=%0d exp=43", n_done); end
    checks++; if (n_starts !== 7) begin errors++; $display("FAIL load_start_count got=%0d exp=7", n_starts); end
    checks++; if (start_instr[0] !== 32'h0000_0481) begin errors++; $display("FAIL load_word0 got=%h exp=00000481", start_instr[0]); end
    checks++; if (start_instr[6] !== 32'h0000_048D) begin errors++; $display("FAIL load_word6 got=%h exp=0000048d", start_instr[6]); end
    checks++; if (bus.result_matrix[199:168] !== 32'hA000_0000) begin errors++; $display("FAIL load_slice0 got=%h exp=a0000000", bus.result_matrix[199:168]); end
    checks++; if (bus.result_matrix[167:136] !== 32'hA000_0001) begin errors++; $display("FAIL load_slice1 got=%h exp=a0000001", bus.result_matrix[167:136]); end
    checks++; if (bus.result_matrix[39:8] !== 32'hA000_0005) begin errors++; $display("FAIL load_slice5 got=%h exp=a0000005", bus.result_matrix[39:8]); end
    checks++; if (bus.result_matrix[7:0] !== 8'hA0) begin errors++; $display("FAIL load_tail got=%h exp=a0", bus.result_matrix[7:0]); end
    checks++; if (bus.overflow_flag !== 1'b0) begin errors++; $display("FAIL load_ovf got=%b exp=0", bus.overflow_flag); end
    tick();
  endtask

  task automatic test_execute();
    accept_cmd(2'b10, 4'b0100, 2'b11, '0);
    run_cmd(5);
    checks++; if (n_done !== 7) begin errors++; $display("FAIL exec_done_cycle got=%0d exp=7", n_done); end
    checks++; if (n_starts !== 1) begin errors++; $display("FAIL exec_start_count got=%0d exp=1", n_starts); end
    checks++; if (start_instr[0][10:5] !== 6'b010011) begin errors++; $display("FAIL exec_fields got=%b exp=010011", start_instr[0][10:5]); end
    checks++; if (start_instr[0] !== 32'h0000_0261) begin errors++; $display("FAIL exec_word got=%h exp=00000261", start_instr[0]); end
    checks++; if (bus.overflow_flag !== 1'b1) begin errors++; $display("FAIL exec_ovf got=%b exp=1", bus.overflow_flag); end
    checks++; if (bus.cmd_error !== 1'b0) begin errors++; $display("FAIL exec_no_error got=%b exp=0", bus.cmd_error); end
    checks++; if (bus.instruction !== 32'h0000_0260) begin errors++; $display("FAIL exec_hold got=%h exp=00000260", bus.instruction); end
    tick();
  endtask

  task automatic test_illegal_execute();
    accept_cmd(2'b10, 4'b1010, 2'b01, '0);
    checks++; if (bus.instruction !== 32'h0000_0260 || bus.done !== 1'b0) begin errors++; $display("FAIL illegal_c0 instr=%h done=%b exp 00000260/0", bus.instruction, bus.done); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.cmd_error !== 1'b1) begin errors++; $display("FAIL illegal_pulse done=%b err=%b exp=1/1", bus.done, bus.cmd_error); end
    checks++; if (bus.instruction[0] !== 1'b0 || bus.overflow_flag !== 1'b1) begin errors++; $display("FAIL illegal_side start=%b ovf=%b exp=0/1", bus.instruction[0], bus.overflow_flag); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.cmd_error !== 1'b0) begin errors++; $display("FAIL illegal_once done=%b err=%b exp=0/0", bus.done, bus.cmd_error); end
  endtask

  task automatic test_back_to_back();
    bus.cmd_kind = 2'b00; bus.cmd_opcode = 4'b0000; bus.cmd_msize = 2'b00; bus.cmd_matrix = mat_a;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_kind = 2'b10; bus.cmd_opcode = 4'b0001; bus.cmd_msize = 2'b01; bus.cmd_matrix = '0;
    run_cmd(-1);
    checks++; if (n_done !== 79 || n_starts !== 13) begin errors++; $display("FAIL b2b_store done=%0d starts=%0d exp=79/13", n_done, n_starts); end
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (start_instr[k][10:7] !== 4'b0111) begin errors++; $display("FAIL b2b_op%0d got=%b exp=0111", k, start_instr[k][10:7]); end
    end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.overflow_flag !== 1'b1) begin errors++; $display("FAIL b2b_done_state ready=%b ovf=%b exp=1/1", bus.cmd_ready, bus.overflow_flag); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.instruction !== 32'h0000_00A1) begin errors++; $display("FAIL b2b_second got=%h exp=000000a1", bus.instruction); end
    run_cmd(5);
    checks++; if (n_done !== 7 || bus.overflow_flag !== 1'b1) begin errors++; $display("FAIL b2b_exec done=%0d ovf=%b exp=7/1", n_done, bus.overflow_flag); end
    tick();
  endtask

  task automatic test_reset_mid_command();
    int guard;
    int done_seen;
    accept_cmd(2'b01, 4'b0000, 2'b00, mat_a);
    guard = 0;
    while (!(bus.instruction[0] && bus.instruction[4:1] == 4'd5) && guard < 100) begin tick(); guard++; end
    checks++; if (guard !== 30) begin errors++; $display("FAIL rstmid_word5 got=%0d exp=30", guard); end
    rst = 1'b1;
    #1;
    checks++; if (bus.instruction !== 32'h0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_now instr=%h ready=%b exp=0/1", bus.instruction, bus.cmd_ready); end
    checks++; if (bus.result_matrix !== 200'h0 || bus.overflow_flag !== 1'b0) begin errors++; $display("FAIL rstmid_clear ovf=%b result=%h exp=0", bus.overflow_flag, bus.result_matrix); end
    done_seen = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) done_seen++;
      tick();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", done_seen); end
    accept_cmd(2'b00, 4'b0000, 2'b00, mat_a);
    run_cmd(-1);
    checks++; if (n_done !== 79 || n_starts !== 13) begin errors++; $display("FAIL rstmid_rerun done=%0d starts=%0d exp=79/13", n_done, n_starts); end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_a();
    test_load();
    test_execute();
    test_illegal_execute();
    test_back_to_back();
    test_reset_mid_command();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
